mem_access_unit: RTL and testbench

Load/store bus sequencer directly downstream of the multicycle control FSM. The FSM starts one data-memory access per load/store instruction using MemWrite, MemOp (funct3 encoding) and the computed address. This block aligns store data, generates byte enables, runs a req/ready handshake with data memory, and sign- or zero-extends load data. It returns a one-cycle done pulse so the FSM can leave its memory state.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory bus between the load/store sequencer and memory.
//   master (sequencer): drives bus_req, bus_we, bus_addr, bus_be, bus_wdata;
//                       samples bus_ready, bus_rdata.
//   slave  (memory)   : the reverse directions.
// bus_req stays high until the cycle in which bus_ready=1 completes the access.
// bus_rdata is only meaningful in that same cycle.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one data-memory access per load/store for the
// multicycle control FSM.
//   It aligns the store data, generates the byte enables, runs the req/ready
//   handshake and extends the load data.
// Ports:
//   clk, rst          rising-edge clock; synchronous active-low reset
//   mem_start         one-cycle access request, sampled only in IDLE
//   MemWrite, MemOp   store/load select and funct3 width/sign encoding
//   Addr, WriteData   byte address and store source
//   bus               memory bus (master side)
//   ReadData          extended load result; holds until the next completed load
//   mem_done          one-cycle completion pulse, also raised on an error
//   mem_busy          high in every state except IDLE
//   misalign_err      sticky flag for misaligned or illegal ops; cleared by the next accepted start
//   timeout_err       sticky flag for an expired bus wait; cleared by the next accepted start
module mem_access_unit #(
    parameter int TIMEOUT = 16              // legal range 2..31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_start,
    input  logic                     MemWrite,
    input  logic [2:0]               MemOp,
    input  logic [31:0]              Addr,
    input  logic [31:0]              WriteData,
    mem_access_unit_if.master        bus,
    output logic [31:0]              ReadData,
    output logic                     mem_done,
    output logic                     mem_busy,
    output logic                     misalign_err,
    output logic                     timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  wait_cnt;

    logic        bad_op;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic        timeout_hit;

    always_comb begin
        // Reject illegal ops along with misaligned ones. The reserved funct3 codes
        // are 011, 110 and 111. A store has no unsigned form (100, 101).
        bad_op = (MemOp == 3'b011) || (MemOp[2:1] == 2'b11) || (MemWrite && MemOp[2])
              || (MemOp[1:0] == 2'b01 && Addr[0])
              || (MemOp[1:0] == 2'b10 && Addr[1:0] != 2'b00);

        be_new    = 4'b1111;
        wdata_new = 32'h0;
        case (MemOp[1:0])
            2'b00: begin
                be_new = 4'b0001 << Addr[1:0];
                if (MemWrite) wdata_new = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_new = Addr[1] ? 4'b1100 : 4'b0011;
                if (MemWrite) wdata_new = {2{WriteData[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                if (MemWrite) wdata_new = WriteData;
            end
        endcase

        // Move the addressed lane down to bit 0 before extending it.
        rd_shift = bus.bus_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  load_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'h0, rd_shift[7:0]};
            3'b101:  load_ext = {16'h0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase

        timeout_hit = (wait_cnt == 5'(TIMEOUT - 1));

        state_nxt = state;
        case (state)
            IDLE: if (mem_start) state_nxt = bad_op ? ERR : REQ;
            REQ: begin
                if (bus.bus_ready)    state_nxt = DONE;
                else if (timeout_hit) state_nxt = ERR;
            end
            default: state_nxt = IDLE;   // DONE and ERR last exactly one cycle
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            op_q          <= 3'b000;
            off_q         <= 2'b00;
            wait_cnt      <= 5'd0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'h0;
            bus.bus_wdata <= 32'h0;
            ReadData      <= 32'h0;
            mem_done      <= 1'b0;
            mem_busy      <= 1'b0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_done <= (state_nxt == DONE) || (state_nxt == ERR);
            mem_busy <= (state_nxt != IDLE);
            case (state)
                IDLE: if (mem_start) begin
                    misalign_err <= bad_op;
                    timeout_err  <= 1'b0;
                    op_q         <= MemOp;
                    off_q        <= Addr[1:0];
                    wait_cnt     <= 5'd0;
                    // A rejected access never reaches the bus.
                    if (!bad_op) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= MemWrite;
                        bus.bus_addr  <= {Addr[31:2], 2'b00};
                        bus.bus_be    <= be_new;
                        bus.bus_wdata <= wdata_new;
                    end
                end
                REQ: begin
                    if (bus.bus_ready || timeout_hit) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= 32'h0;
                        bus.bus_be    <= 4'h0;
                        bus.bus_wdata <= 32'h0;
                    end
                    if (bus.bus_ready) begin
                        if (!bus.bus_we) ReadData <= load_ext;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of mem_access_unit, with one task per scenario.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  MemOp = 3'b000;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        mem_done, mem_busy, misalign_err, timeout_err;

    int checks = 0;
    int failures = 0;

    mem_access_unit_if bus_if();

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_start    (mem_start),
        .MemWrite     (MemWrite),
        .MemOp        (MemOp),
        .Addr         (Addr),
        .WriteData    (WriteData),
        .bus          (bus_if),
        .ReadData     (ReadData),
        .mem_done     (mem_done),
        .mem_busy     (mem_busy),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Presents one request that the DUT samples at the next rising edge.
    // The task returns 1 time unit after that edge.
    task automatic do_start(input logic we, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd);
        @(negedge clk);
        mem_start = 1'b1; MemWrite = we; MemOp = op; Addr = a; WriteData = wd;
        @(posedge clk); #1;
        mem_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.bus_req !== 1'b0) begin failures++; $display("FAIL reset_req actual=%b required=0", bus_if.bus_req); end
        checks++; if ({bus_if.bus_we, bus_if.bus_be} !== 5'h0) begin failures++; $display("FAIL reset_we_be actual=%h required=0", {bus_if.bus_we, bus_if.bus_be}); end
        checks++; if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'h0) begin failures++; $display("FAIL reset_addr_wdata actual=%h required=0", {bus_if.bus_addr, bus_if.bus_wdata}); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_rdata actual=%h required=0", ReadData); end
        checks++; if ({mem_done, mem_busy, misalign_err, timeout_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags actual=%b required=0000", {mem_done, mem_busy, misalign_err, timeout_err}); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_lb_zero_wait;
        do_start(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        bus_if.bus_rdata = 32'h80FF_1234; bus_if.bus_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.bus_req !== 1'b1) begin failures++; $display("FAIL lb_req actual=%b required=1", bus_if.bus_req); end
        checks++; if (bus_if.bus_addr !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr actual=%h required=00001000", bus_if.bus_addr); end
        checks++; if (bus_if.bus_be !== 4'b1000) begin failures++; $display("FAIL lb_be actual=%b required=1000", bus_if.bus_be); end
        checks++; if ({bus_if.bus_we, bus_if.bus_wdata} !== 33'h0) begin failures++; $display("FAIL lb_we_wdata actual=%h required=0", {bus_if.bus_we, bus_if.bus_wdata}); end
        checks++; if ({mem_done, mem_busy} !== 2'b01) begin failures++; $display("FAIL lb_busy actual=%b required=01", {mem_done, mem_busy}); end
        @(posedge clk); #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL lb_done actual=%b required=1", mem_done); end
        checks++; if (bus_if.bus_req !== 1'b0) begin failures++; $display("FAIL lb_req_drop actual=%b required=0", bus_if.bus_req); end
        checks++; if (ReadData !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata actual=%h required=ffffff80", ReadData); end
        @(negedge clk);
        checks++; if ({mem_done, mem_busy} !== 2'b00) begin failures++; $display("FAIL lb_done_once actual=%b required=00", {mem_done, mem_busy}); end
    endtask

    task automatic test_lhu_wait;
        do_start(1'b0, 3'b101, 32'h0000_2002, 32'h0);
        bus_if.bus_rdata = 32'hBEEF_0000; bus_if.bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, mem_done} !== {1'b1, 1'b0, 4'b1100, 32'h0000_2000, 1'b0}) begin
                failures++;
                $display("FAIL lhu_stable cycle=%0d actual req=%b we=%b be=%b addr=%h done=%b required req=1 we=0 be=1100 addr=00002000 done=0",
                         i, bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, mem_done);
            end
            if (i == 3) bus_if.bus_ready = 1'b1;
        end
        @(posedge clk); #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if ({bus_if.bus_req, mem_done} !== 2'b01) begin failures++; $display("FAIL lhu_done actual=%b required=01", {bus_if.bus_req, mem_done}); end
        checks++; if (ReadData !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_rdata actual=%h required=0000beef", ReadData); end
    endtask

    task automatic test_sb;
        do_start(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB);
        bus_if.bus_rdata = 32'hDEAD_DEAD; bus_if.bus_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus_if.bus_req, bus_if.bus_we} !== 2'b11) begin failures++; $display("FAIL sb_req_we actual=%b required=11", {bus_if.bus_req, bus_if.bus_we}); end
        checks++; if (bus_if.bus_be !== 4'b0010) begin failures++; $display("FAIL sb_be actual=%b required=0010", bus_if.bus_be); end
        checks++; if (bus_if.bus_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata actual=%h required=abababab", bus_if.bus_wdata); end
        checks++; if (bus_if.bus_addr !== 32'h0000_0100) begin failures++; $display("FAIL sb_addr actual=%h required=00000100", bus_if.bus_addr); end
        @(posedge clk); #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL sb_done actual=%b required=1", mem_done); end
        checks++; if (ReadData !== 32'h0000_BEEF) begin failures++; $display("FAIL sb_rdata_kept actual=%h required=0000beef", ReadData); end
    endtask

    task automatic test_misalign;
        do_start(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        @(negedge clk);
        checks++; if (bus_if.bus_req !== 1'b0) begin failures++; $display("FAIL mis_no_req actual=%b required=0", bus_if.bus_req); end
        checks++; if ({misalign_err, timeout_err, mem_done, mem_busy} !== 4'b1011) begin failures++; $display("FAIL mis_flags actual=%b required=1011", {misalign_err, timeout_err, mem_done, mem_busy}); end
        @(negedge clk);
        checks++; if ({mem_done, misalign_err} !== 2'b01) begin failures++; $display("FAIL mis_sticky actual=%b required=01", {mem_done, misalign_err}); end
        // A valid SW clears the flag.
        do_start(1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D);
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL sw_clears actual=%b required=0", misalign_err); end
        checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'b111111) begin failures++; $display("FAIL sw_req_be actual=%b required=111111", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
        checks++; if (bus_if.bus_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL sw_wdata actual=%h required=cafef00d", bus_if.bus_wdata); end
        @(posedge clk); #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL sw_done actual=%b required=1", mem_done); end
        // Illegal ops: a store with the unsigned encoding, and reserved funct3 110.
        // An LH at an odd address is misaligned.
        do_start(1'b1, 3'b100, 32'h0000_0010, 32'h0);
        @(negedge clk);
        checks++; if ({bus_if.bus_req, misalign_err, mem_done} !== 3'b011) begin failures++; $display("FAIL illegal_sbu actual=%b required=011", {bus_if.bus_req, misalign_err, mem_done}); end
        do_start(1'b0, 3'b110, 32'h0000_0010, 32'h0);
        @(negedge clk);
        checks++; if ({bus_if.bus_req, misalign_err, mem_done} !== 3'b011) begin failures++; $display("FAIL illegal_110 actual=%b required=011", {bus_if.bus_req, misalign_err, mem_done}); end
        do_start(1'b0, 3'b001, 32'h0000_0011, 32'h0);
        @(negedge clk);
        checks++; if ({bus_if.bus_req, misalign_err, mem_done} !== 3'b011) begin failures++; $display("FAIL lh_odd actual=%b required=011", {bus_if.bus_req, misalign_err, mem_done}); end
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        int done_pulses = 0;
        do_start(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        bus_if.bus_ready = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus_if.bus_req) req_cycles++;
            if (mem_done) done_pulses++;
        end
        checks++; if (req_cycles != 16) begin failures++; $display("FAIL to_req_cycles actual=%0d required=16", req_cycles); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL to_done_pulses actual=%0d required=1", done_pulses); end
        checks++; if ({timeout_err, misalign_err, mem_busy} !== 3'b100) begin failures++; $display("FAIL to_flags actual=%b required=100", {timeout_err, misalign_err, mem_busy}); end
        checks++; if (ReadData !== 32'h0000_BEEF) begin failures++; $display("FAIL to_rdata_kept actual=%h required=0000beef", ReadData); end
    endtask

    task automatic test_reset_in_req;
        do_start(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        bus_if.bus_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;      // now in the second REQ cycle
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'h0) begin failures++; $display("FAIL rr_bus_ctl actual=%b required=0", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
        checks++; if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'h0) begin failures++; $display("FAIL rr_bus_data actual=%h required=0", {bus_if.bus_addr, bus_if.bus_wdata}); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rr_rdata actual=%h required=0", ReadData); end
        checks++; if ({mem_done, mem_busy, misalign_err, timeout_err} !== 4'b0000) begin failures++; $display("FAIL rr_flags actual=%b required=0000", {mem_done, mem_busy, misalign_err, timeout_err}); end
        // A fresh LH after reset sign-extends from bit 15 of the upper half.
        do_start(1'b0, 3'b001, 32'h0000_1002, 32'h0);
        bus_if.bus_rdata = 32'h9234_007F; bus_if.bus_ready = 1'b1;
        @(posedge clk); #1 bus_if.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL rr_new_done actual=%b required=1", mem_done); end
        checks++; if (ReadData !== 32'hFFFF_9234) begin failures++; $display("FAIL rr_new_rdata actual=%h required=ffff9234", ReadData); end
    endtask

    initial begin
        test_reset();
        test_lb_zero_wait();
        test_lhu_wait();
        test_sb();
        test_misalign();
        test_timeout();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
